sram_2p_rd_stream: RTL
======================

Name: sram_2p_rd_stream

Overview:
Read-side engine for the two-port SRAM buffer.
- Given a start address and a word count, it drives the SRAM read port (iRdB/iAddrB), absorbs the 1-cycle SRAM read latency, and presents the words as a valid/ready stream.
- Sits between the frame buffer and the downstream consumer, e.g. the MAC transmit path.
- Sustains 1 word/cycle under continuous iReady, with no bubbles.

Parameters:
AW, 5, SRAM address width; must match the SRAM instance.
DW, 32, data width; must match the SRAM instance.
LW, AW+1, length field width; allows a full 2^AW-word transfer.

Ports:
clk  input  1  single clock; SRAM port B is clocked by this clock.
reset  input  1  asynchronous, active-high reset.
iStart  input  1  start request; accepted only in IDLE.
iBaseAddr  input  AW  first word address, sampled on accept.
iLen  input  LW  number of words, sampled on accept.
oBusy  output  1  transfer in progress.
oDone  output  1  one-cycle pulse at transfer end.
oRdB  output  1  to SRAM iRdB.
oAddrB  output  AW  to SRAM iAddrB.
iDataB  input  DW  from SRAM oDataB.
oValid  output  1  stream word valid.
iReady  input  1  consumer accepts the word.
oData  output  DW  stream data.
oLast  output  1  marks the final word of the transfer.

Behaviour:
- Reset values: oBusy=0, oDone=0, oRdB=0, oAddrB=0, oValid=0, oData=0, oLast=0; FSM=IDLE; FIFO empty; counters=0.
- FSM states and transitions:
  - IDLE to RUN when iStart=1 and iLen!=0.
  - IDLE to DONE when iStart=1 and iLen==0. No reads or beats occur in this case.
  - RUN to DONE on the handshake (oValid & iReady) of the word tagged last.
  - DONE to IDLE unconditionally after one cycle; oDone=1 only in DONE.
- oBusy=1 in RUN only. iStart is ignored while in RUN or DONE.
- Read issue: oRdB is combinational and equals RUN & (issued<len) & (inflight+fifo_count<2).
  - oAddrB is the current read address.
  - The address increments by 1 per issued read and wraps modulo 2^AW, so 31 is followed by 0.
- Capture: a registered rd_pending flag marks a read issued in the previous cycle. iDataB is pushed into the 2-entry FIFO only when rd_pending=1. The SRAM's held output is never re-sampled.
- The credit rule guarantees the FIFO never overflows; no push is ever dropped.
- Latency: iStart accepted at edge k → oRdB high during cycle k..k+1 → oValid high after edge k+2.
- oData/oLast come from the FIFO head; oLast is the tag stored with the final issued read.
- Backpressure: while iReady=0, the FIFO head and oValid hold stable, and no read is issued once the credit of 2 is exhausted.
- A simultaneous FIFO push and pop leaves the count unchanged.
- Reset mid-transfer: immediate return to IDLE, FIFO flushed, rd_pending cleared, no oDone pulse.

Optional Feature:
RD_STREAM_ABORT_EN
- Defined: adds iAbort (input, 1). iAbort=1 in RUN flushes the FIFO, discards any pending read capture, forces oValid=0 next cycle, and enters DONE, which pulses oDone. iAbort is ignored in IDLE and DONE.
- Undefined: the port is absent and a transfer always runs to completion.

Decomposition:
- Shared package mac_sram_pkg holds:
  - FSM state encodings (IDLE/RUN/DONE).
  - The FIFO depth constant (2).
  - Default AW/DW.
- Sub-module sram_rd_fifo2: 2-entry DW+1-bit FIFO with push/pop/count/flush, same clk/reset.

Test Plan:
- Len=4 from addr 3, iReady=1, SRAM preloaded mem[k]=k+100 → oData 103,104,105,106 on 4 consecutive cycles; oLast on 106; oDone pulses 1 cycle later; first oValid 2 cycles after iStart.
- Wrap: base=30, len=4 → read addresses 30,31,0,1; data in the same order.
- Backpressure: len=6, iReady toggles 1,0,0,1,… → no word lost or duplicated; oData stable while iReady=0; oRdB never high when inflight+fifo=2.
- Len=0 → no oRdB or oValid; oDone pulses one cycle after iStart.
- iStart asserted again while busy → ignored, beat count unchanged; reset pulsed mid-transfer → all outputs 0 next cycle, no oDone, a new transfer starts cleanly.
- (RD_STREAM_ABORT_EN) iAbort after 2 of 8 beats → oValid low next cycle, oDone pulse, FIFO empty, oBusy=0.

Source files
------------

// File: rtl/mac_sram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mac_sram_pkg
// Purpose  : Shared definitions for the two-port SRAM buffer read engine:
//            FSM state encoding, read FIFO depth, and default SRAM geometry.
// Revision : 1.0 - initial release
// ============================================================================
package mac_sram_pkg;

    localparam int c_AW_DEFAULT = 5;
    localparam int c_DW_DEFAULT = 32;

    // Staging FIFO depth; this also serves as the read credit limit.
    localparam int c_FIFO_DEPTH = 2;
    localparam int c_FIFO_CW    = $clog2(c_FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } rd_state_e;

endpackage
`default_nettype wire

// File: rtl/sram_rd_fifo2.sv
`default_nettype none
// ============================================================================
// Module   : sram_rd_fifo2
// Purpose  : Two-entry staging FIFO that holds SRAM read data plus its tag bit
//            until the stream consumer accepts it. Flush takes priority over
//            push and pop.
// Ports    : clk, reset (async, active-high)
//            flush     - empty the FIFO
//            push      - write push_data
//            pop       - drop the head entry (caller guarantees non-empty)
//            head      - current head entry
//            count     - occupancy, 0..2
// Revision : 1.0 - initial release
// ============================================================================
module sram_rd_fifo2
    import mac_sram_pkg::*;
#(
    parameter int W = c_DW_DEFAULT + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 push,
    input  logic [W-1:0]         push_data,
    input  logic                 pop,
    output logic [W-1:0]         head,
    output logic [c_FIFO_CW-1:0] count
);

    logic [W-1:0]         mem_q [c_FIFO_DEPTH];
    logic [W-1:0]         mem_d [c_FIFO_DEPTH];
    logic                 wr_ptr_q, wr_ptr_d;
    logic                 rd_ptr_q, rd_ptr_d;
    logic [c_FIFO_CW-1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({push, pop})
                2'b10:   count_d = count_q + c_FIFO_CW'(1);
                2'b01:   count_d = count_q - c_FIFO_CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < c_FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/sram_2p_rd_stream.sv
`default_nettype none
// ============================================================================
// Module   : sram_2p_rd_stream
// Purpose  : Read-side engine for the two-port SRAM buffer. Reads iLen words
//            starting at iBaseAddr (address wraps modulo 2^AW), absorbs the
//            one-cycle SRAM read latency and presents the words as a
//            valid/ready stream with a last marker.
// Ports    : clk, reset (async, active-high)
//            iStart/iBaseAddr/iLen - transfer request, accepted in IDLE only
//            oBusy  - transfer running;  oDone - one-cycle end pulse
//            oRdB/oAddrB/iDataB    - SRAM port B
//            oValid/iReady/oData/oLast - output stream
//            iAbort - present only when RD_STREAM_ABORT_EN is defined
// Build    : define RD_STREAM_ABORT_EN to add the iAbort input.
// Revision : 1.0 - initial release
// ============================================================================
module sram_2p_rd_stream
    import mac_sram_pkg::*;
#(
    parameter int AW = c_AW_DEFAULT,
    parameter int DW = c_DW_DEFAULT,
    parameter int LW = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          iStart,
    input  logic [AW-1:0] iBaseAddr,
    input  logic [LW-1:0] iLen,
`ifdef RD_STREAM_ABORT_EN
    input  logic          iAbort,
`endif
    output logic          oBusy,
    output logic          oDone,
    output logic          oRdB,
    output logic [AW-1:0] oAddrB,
    input  logic [DW-1:0] iDataB,
    output logic          oValid,
    input  logic          iReady,
    output logic [DW-1:0] oData,
    output logic          oLast
);

    rd_state_e            state_q, state_d;
    logic [LW-1:0]        len_q, len_d;
    logic [LW-1:0]        issued_q, issued_d;
    logic [AW-1:0]        addr_q, addr_d;
    logic                 rd_pending_q, rd_pending_d;
    logic                 last_pend_q, last_pend_d;

    logic [DW:0]          fifo_head;
    logic [c_FIFO_CW-1:0] fifo_count;
    logic [c_FIFO_CW:0]   credit_used;
    logic                 fifo_valid;
    logic                 pop;
    logic                 push;
    logic                 abort;
    logic                 rd_en;

`ifdef RD_STREAM_ABORT_EN
    assign abort = (state_q == ST_RUN) && iAbort;
`else
    assign abort = 1'b0;
`endif

    assign fifo_valid = (fifo_count != '0);
    assign pop        = fifo_valid && iReady;

    // Credit = reads in flight + words staged. A word leaving the FIFO this
    // cycle frees its slot, which is what allows one issue per cycle under
    // continuous iReady without ever exceeding the two FIFO entries.
    assign credit_used = {1'b0, fifo_count}
                       + {{c_FIFO_CW{1'b0}}, rd_pending_q}
                       - {{c_FIFO_CW{1'b0}}, pop};

    assign rd_en = (state_q == ST_RUN)
                && (issued_q < len_q)
                && (credit_used < (c_FIFO_CW + 1)'(c_FIFO_DEPTH));

    // Only a read issued last cycle is captured; the SRAM's held output is
    // never sampled twice. An abort discards the capture.
    assign push = rd_pending_q && !abort;

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        issued_d     = issued_q;
        addr_d       = addr_q;
        rd_pending_d = 1'b0;
        last_pend_d  = last_pend_q;
        case (state_q)
            ST_IDLE: begin
                if (iStart) begin
                    len_d    = iLen;
                    issued_d = '0;
                    addr_d   = iBaseAddr;
                    state_d  = (iLen != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (rd_en) begin
                    addr_d       = addr_q + AW'(1);
                    issued_d     = issued_q + LW'(1);
                    rd_pending_d = 1'b1;
                    last_pend_d  = (issued_q == len_q - LW'(1));
                end
                if (pop && fifo_head[DW]) begin
                    state_d = ST_DONE;
                end
                if (abort) begin
                    state_d      = ST_DONE;
                    rd_pending_d = 1'b0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            len_q        <= '0;
            issued_q     <= '0;
            addr_q       <= '0;
            rd_pending_q <= 1'b0;
            last_pend_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            issued_q     <= issued_d;
            addr_q       <= addr_d;
            rd_pending_q <= rd_pending_d;
            last_pend_q  <= last_pend_d;
        end
    end

    sram_rd_fifo2 #(
        .W (DW + 1)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (abort),
        .push      (push),
        .push_data ({last_pend_q, iDataB}),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    assign oBusy  = (state_q == ST_RUN);
    assign oDone  = (state_q == ST_DONE);
    assign oRdB   = rd_en;
    assign oAddrB = addr_q;
    assign oValid = fifo_valid;
    assign oData  = fifo_head[DW-1:0];
    assign oLast  = fifo_valid && fifo_head[DW];

endmodule
`default_nettype wire
